z_fragment_dispatch: RTL and testbench
======================================

// Module: z_fragment_dispatch
// PURPOSE
//  Stage directly upstream of z_buffer. Buffers rasterised fragments (x, y, z, colour) in a small FIFO.
//  Issues one depth test per fragment using z_buffer's start/done protocol.
//  Forwards only depth-passing fragments to the colour writer over a valid/ready port.
//  Also sequences depth-buffer clear (flush) requests and keeps pass/fail statistics.
// PARAMETERS
//  X_RES        4   horizontal resolution in pixels
//  Y_RES        4   vertical resolution in pixels
//  X_PIXEL_SIZE $clog2(X_RES)  x coordinate width
//  Y_PIXEL_SIZE $clog2(Y_RES)  y coordinate width
//  Z_SIZE       8   depth width
//  COLOUR_SIZE  16  fragment colour width
//  FIFO_DEPTH   4   input fragment FIFO entries (power of 2, >=2)
//  STAT_SIZE    16  statistic counter width
// PORTS
//  clk_i            in   1             clock
//  rst_i            in   1             reset, asynchronous, active-high
//  frag_valid_i     in   1             upstream fragment valid
//  frag_ready_o     out  1             FIFO can accept a fragment
//  frag_x_i         in   X_PIXEL_SIZE  fragment x
//  frag_y_i         in   Y_PIXEL_SIZE  fragment y
//  frag_z_i         in   Z_SIZE        fragment depth
//  frag_colour_i    in   COLOUR_SIZE   fragment colour
//  clear_req_i      in   1             level request: clear depth buffer
//  clear_ack_o      out  1             1-cycle pulse: clear finished
//  zb_start_o       out  1             z_buffer start_i
//  zb_flush_o       out  1             z_buffer flush_i
//  zb_pixel_x_o     out  X_PIXEL_SIZE  z_buffer pixel_x_i
//  zb_pixel_y_o     out  Y_PIXEL_SIZE  z_buffer pixel_y_i
//  zb_pixel_z_o     out  Z_SIZE        z_buffer pixel_z_i
//  zb_done_i        in   1             z_buffer done_o
//  zb_depth_pass_i  in   1             z_buffer depth_pass_o
//  out_valid_o      out  1             passed fragment valid
//  out_ready_i      in   1             colour writer ready
//  out_x_o          out  X_PIXEL_SIZE  passed fragment x
//  out_y_o          out  Y_PIXEL_SIZE  passed fragment y
//  out_colour_o     out  COLOUR_SIZE   passed fragment colour
//  pass_count_o     out  STAT_SIZE     fragments passed since reset
//  fail_count_o     out  STAT_SIZE     fragments rejected since reset
//  busy_o           out  1             FIFO non-empty, or FSM not in IDLE
// BEHAVIOUR
//  Reset: every output is 0; FIFO is emptied; FSM goes to IDLE; counters are 0. Reset applies asynchronously, even mid-test.
//  FIFO handshake:
//   - A push occurs on frag_valid_i & frag_ready_o.
//   - frag_ready_o = !full & !clear_pending.
//   - A pop occurs when IDLE issues a fragment.
//   - Push and pop in the same cycle are legal when full; occupancy is unchanged.
//  FSM states: IDLE, ISSUE, WAIT, EMIT, CLEAR, COOL.
//  IDLE:
//   - If clear_pending and FIFO empty -> CLEAR.
//   - Else if FIFO non-empty -> ISSUE; pop the head into the current-fragment register cur_*.
//   - Clear takes priority once the FIFO is drained. clear_pending is set on clear_req_i.
//  ISSUE: zb_start_o=1 for exactly this cycle; zb_flush_o=0 -> WAIT.
//  WAIT:
//   - Hold on zb_pixel_* = cur_* until done. These are held stable from ISSUE until leaving WAIT, since z_buffer samples them combinationally.
//   - When zb_done_i=1: sample zb_depth_pass_i.
//     pass -> EMIT, pass_count+1.
//     fail -> COOL, fail_count+1.
//  EMIT:
//   - out_valid_o=1, out_* = cur_*, held until out_ready_i.
//   - On handshake -> COOL.
//   - Backpressure stalls the stage; the FIFO keeps accepting until full.
//  CLEAR:
//   - zb_start_o=1 and zb_flush_o=1 for the first cycle only; zb_pixel_* = 0.
//   - On zb_done_i -> COOL; clear_ack_o=1 that cycle; clear_pending cleared.
//  COOL: one idle cycle so z_buffer returns to its IDLE state and drops done_o -> IDLE. Minimum 4 dispatcher cycles per fragment.
//  zb_done_i is ignored outside WAIT and CLEAR.
//  Counters saturate at all-ones and do not wrap.
//  clear_req_i asserted while a clear is already pending has no further effect.
//  out_* hold their value when out_valid_o=0.
// STRUCTURE
//  raster_pkg holds: fragment struct typedef (x, y, z, colour); dispatch state enum; z-func enum shared with z_buffer.
//  Sub-module frag_fifo: generic synchronous FIFO (WIDTH, DEPTH), with full/empty, async active-high reset.
//  Top level holds the FSM, cur_* registers and counters.
// TESTING
//  1. Single fragment (1,2,z=5), zb model returns pass after 3 cycles -> zb_start_o 1 pulse; out (1,2,colour) once; pass_count=1.
//  2. Fragment whose zb model returns fail -> no out_valid_o; fail_count=1; busy_o drops within 2 cycles of done.
//  3. Push 6 fragments back-to-back, FIFO_DEPTH=4, out_ready_i=0 for 20 cycles -> frag_ready_o=0 when full; no loss or reorder; all 6 emitted in order.
//  4. clear_req_i with 2 queued -> both tested first; then zb_start_o&zb_flush_o pulse; clear_ack_o 1 cycle after zb_done_i; frag_ready_o=0 meanwhile.
//  5. Assert rst_i during WAIT -> all outputs 0 immediately; FIFO empty; next fragment processed normally.
//  6. Force 2^STAT_SIZE+3 passes (STAT_SIZE=4 build) -> pass_count_o stays 15.

Source files
------------

// File: rtl/raster_pkg.sv
// Shared types for the rasteriser back end: fragment record, dispatcher
// state encoding and the depth-compare function used by z_buffer.
package raster_pkg;

  localparam int X_RES_DEF       = 4;
  localparam int Y_RES_DEF       = 4;
  localparam int X_PIXEL_DEF     = $clog2(X_RES_DEF);
  localparam int Y_PIXEL_DEF     = $clog2(Y_RES_DEF);
  localparam int Z_SIZE_DEF      = 8;
  localparam int COLOUR_SIZE_DEF = 16;

  // Fragment layout at the default build widths; modules with other widths
  // declare a local struct with the same field order.
  typedef struct packed {
    logic [X_PIXEL_DEF-1:0]     x;
    logic [Y_PIXEL_DEF-1:0]     y;
    logic [Z_SIZE_DEF-1:0]      z;
    logic [COLOUR_SIZE_DEF-1:0] colour;
  } frag_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_EMIT  = 3'd3,
    ST_CLEAR = 3'd4,
    ST_COOL  = 3'd5
  } dispatch_state_e;

  typedef enum logic [1:0] {
    ZF_LESS    = 2'd0,
    ZF_LEQUAL  = 2'd1,
    ZF_GREATER = 2'd2,
    ZF_ALWAYS  = 2'd3
  } z_func_e;

endpackage

// File: rtl/frag_fifo.sv
// Generic synchronous FIFO with show-ahead head output; DEPTH must be a
// power of two. Pointers carry one extra wrap bit to separate full from empty.
module frag_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  // A pop frees the slot the simultaneous push lands in, so full is no barrier then.
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

  assign o_data = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/z_fragment_dispatch.sv
// Queues rasterised fragments, runs one z_buffer depth test per fragment,
// forwards passing fragments and sequences depth-buffer clears.
module z_fragment_dispatch
  import raster_pkg::*;
#(
  parameter int X_RES        = 4,
  parameter int Y_RES        = 4,
  parameter int X_PIXEL_SIZE = $clog2(X_RES),
  parameter int Y_PIXEL_SIZE = $clog2(Y_RES),
  parameter int Z_SIZE       = 8,
  parameter int COLOUR_SIZE  = 16,
  parameter int FIFO_DEPTH   = 4,
  parameter int STAT_SIZE    = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    frag_valid_i,
  output logic                    frag_ready_o,
  input  logic [X_PIXEL_SIZE-1:0] frag_x_i,
  input  logic [Y_PIXEL_SIZE-1:0] frag_y_i,
  input  logic [Z_SIZE-1:0]       frag_z_i,
  input  logic [COLOUR_SIZE-1:0]  frag_colour_i,
  input  logic                    clear_req_i,
  output logic                    clear_ack_o,
  output logic                    zb_start_o,
  output logic                    zb_flush_o,
  output logic [X_PIXEL_SIZE-1:0] zb_pixel_x_o,
  output logic [Y_PIXEL_SIZE-1:0] zb_pixel_y_o,
  output logic [Z_SIZE-1:0]       zb_pixel_z_o,
  input  logic                    zb_done_i,
  input  logic                    zb_depth_pass_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [X_PIXEL_SIZE-1:0] out_x_o,
  output logic [Y_PIXEL_SIZE-1:0] out_y_o,
  output logic [COLOUR_SIZE-1:0]  out_colour_o,
  output logic [STAT_SIZE-1:0]    pass_count_o,
  output logic [STAT_SIZE-1:0]    fail_count_o,
  output logic                    busy_o
);

  localparam int FRAG_W = X_PIXEL_SIZE + Y_PIXEL_SIZE + Z_SIZE + COLOUR_SIZE;
  localparam logic [STAT_SIZE-1:0] STAT_ONE = {{(STAT_SIZE-1){1'b0}}, 1'b1};

  typedef struct packed {
    logic [X_PIXEL_SIZE-1:0] x;
    logic [Y_PIXEL_SIZE-1:0] y;
    logic [Z_SIZE-1:0]       z;
    logic [COLOUR_SIZE-1:0]  colour;
  } dfrag_t;

  dispatch_state_e         r_state;
  logic                    r_live;
  logic                    r_clear_pending;
  logic [X_PIXEL_SIZE-1:0] r_cur_x;
  logic [Y_PIXEL_SIZE-1:0] r_cur_y;
  logic [COLOUR_SIZE-1:0]  r_cur_colour;
  logic                    r_zb_start;
  logic                    r_zb_flush;
  logic [X_PIXEL_SIZE-1:0] r_zb_x;
  logic [Y_PIXEL_SIZE-1:0] r_zb_y;
  logic [Z_SIZE-1:0]       r_zb_z;
  logic                    r_clear_ack;
  logic                    r_out_valid;
  logic [X_PIXEL_SIZE-1:0] r_out_x;
  logic [Y_PIXEL_SIZE-1:0] r_out_y;
  logic [COLOUR_SIZE-1:0]  r_out_colour;
  logic [STAT_SIZE-1:0]    r_pass_count;
  logic [STAT_SIZE-1:0]    r_fail_count;

  dfrag_t w_fifo_din;
  dfrag_t w_fifo_dout;
  logic   w_fifo_full;
  logic   w_fifo_empty;
  logic   w_push;
  logic   w_pop;

  assign w_fifo_din = {frag_x_i, frag_y_i, frag_z_i, frag_colour_i};

  // r_live keeps frag_ready_o low while reset is held and for the first cycle after.
  assign frag_ready_o = r_live & ~w_fifo_full & ~r_clear_pending;
  assign w_push       = frag_valid_i & frag_ready_o;
  assign w_pop        = (r_state == ST_IDLE) & ~w_fifo_empty;
  assign busy_o       = ~w_fifo_empty | (r_state != ST_IDLE);

  frag_fifo #(
    .WIDTH (FRAG_W),
    .DEPTH (FIFO_DEPTH)
  ) u_frag_fifo (
    .i_clk   (clk_i),
    .i_rst   (rst_i),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_fifo_din),
    .o_data  (w_fifo_dout),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state         <= ST_IDLE;
      r_live          <= 1'b0;
      r_clear_pending <= 1'b0;
      r_cur_x         <= '0;
      r_cur_y         <= '0;
      r_cur_colour    <= '0;
      r_zb_start      <= 1'b0;
      r_zb_flush      <= 1'b0;
      r_zb_x          <= '0;
      r_zb_y          <= '0;
      r_zb_z          <= '0;
      r_clear_ack     <= 1'b0;
      r_out_valid     <= 1'b0;
      r_out_x         <= '0;
      r_out_y         <= '0;
      r_out_colour    <= '0;
      r_pass_count    <= '0;
      r_fail_count    <= '0;
    end else begin
      r_live      <= 1'b1;
      r_zb_start  <= 1'b0;
      r_zb_flush  <= 1'b0;
      r_clear_ack <= 1'b0;

      // The requester still holds clear_req_i while it sees the ack; ignore that cycle.
      if (clear_req_i && !r_clear_ack) r_clear_pending <= 1'b1;

      case (r_state)
        ST_IDLE: begin
          if (r_clear_pending && w_fifo_empty) begin
            r_state    <= ST_CLEAR;
            r_zb_start <= 1'b1;
            r_zb_flush <= 1'b1;
            r_zb_x     <= '0;
            r_zb_y     <= '0;
            r_zb_z     <= '0;
          end else if (!w_fifo_empty) begin
            r_state      <= ST_ISSUE;
            r_cur_x      <= w_fifo_dout.x;
            r_cur_y      <= w_fifo_dout.y;
            r_cur_colour <= w_fifo_dout.colour;
            r_zb_start   <= 1'b1;
            r_zb_x       <= w_fifo_dout.x;
            r_zb_y       <= w_fifo_dout.y;
            r_zb_z       <= w_fifo_dout.z;
          end
        end
        ST_ISSUE: r_state <= ST_WAIT;
        ST_WAIT: begin
          if (zb_done_i) begin
            if (zb_depth_pass_i) begin
              r_state      <= ST_EMIT;
              r_out_valid  <= 1'b1;
              r_out_x      <= r_cur_x;
              r_out_y      <= r_cur_y;
              r_out_colour <= r_cur_colour;
              if (r_pass_count != '1) r_pass_count <= r_pass_count + STAT_ONE;
            end else begin
              r_state <= ST_COOL;
              if (r_fail_count != '1) r_fail_count <= r_fail_count + STAT_ONE;
            end
          end
        end
        ST_EMIT: begin
          if (out_ready_i) begin
            r_state     <= ST_COOL;
            r_out_valid <= 1'b0;
          end
        end
        ST_CLEAR: begin
          if (zb_done_i) begin
            r_state         <= ST_COOL;
            r_clear_ack     <= 1'b1;
            r_clear_pending <= 1'b0;
          end
        end
        ST_COOL: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign zb_start_o   = r_zb_start;
  assign zb_flush_o   = r_zb_flush;
  assign zb_pixel_x_o = r_zb_x;
  assign zb_pixel_y_o = r_zb_y;
  assign zb_pixel_z_o = r_zb_z;
  assign clear_ack_o  = r_clear_ack;
  assign out_valid_o  = r_out_valid;
  assign out_x_o      = r_out_x;
  assign out_y_o      = r_out_y;
  assign out_colour_o = r_out_colour;
  assign pass_count_o = r_pass_count;
  assign fail_count_o = r_fail_count;

endmodule

// File: tb/tb_z_fragment_dispatch.sv
// Bench for z_fragment_dispatch: z_buffer model (pass iff z < 128), fragment
// table, issue/output scoreboards and hand-written clear/reset sequences.
module tb_z_fragment_dispatch;

  localparam int XW = 2;
  localparam int YW = 2;
  localparam int ZW = 8;
  localparam int CW = 16;
  localparam int SW = 4;
  localparam int SAT = 15;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          frag_valid_i;
  logic          frag_ready_o;
  logic [XW-1:0] frag_x_i;
  logic [YW-1:0] frag_y_i;
  logic [ZW-1:0] frag_z_i;
  logic [CW-1:0] frag_colour_i;
  logic          clear_req_i;
  logic          clear_ack_o;
  logic          zb_start_o;
  logic          zb_flush_o;
  logic [XW-1:0] zb_pixel_x_o;
  logic [YW-1:0] zb_pixel_y_o;
  logic [ZW-1:0] zb_pixel_z_o;
  logic          zb_done_i;
  logic          zb_depth_pass_i;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [XW-1:0] out_x_o;
  logic [YW-1:0] out_y_o;
  logic [CW-1:0] out_colour_o;
  logic [SW-1:0] pass_count_o;
  logic [SW-1:0] fail_count_o;
  logic          busy_o;

  always #5 clk_i = ~clk_i;

  z_fragment_dispatch #(
    .X_RES(4), .Y_RES(4), .Z_SIZE(ZW), .COLOUR_SIZE(CW),
    .FIFO_DEPTH(4), .STAT_SIZE(SW)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .frag_valid_i(frag_valid_i), .frag_ready_o(frag_ready_o),
    .frag_x_i(frag_x_i), .frag_y_i(frag_y_i), .frag_z_i(frag_z_i),
    .frag_colour_i(frag_colour_i),
    .clear_req_i(clear_req_i), .clear_ack_o(clear_ack_o),
    .zb_start_o(zb_start_o), .zb_flush_o(zb_flush_o),
    .zb_pixel_x_o(zb_pixel_x_o), .zb_pixel_y_o(zb_pixel_y_o), .zb_pixel_z_o(zb_pixel_z_o),
    .zb_done_i(zb_done_i), .zb_depth_pass_i(zb_depth_pass_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_x_o(out_x_o), .out_y_o(out_y_o), .out_colour_o(out_colour_o),
    .pass_count_o(pass_count_o), .fail_count_o(fail_count_o),
    .busy_o(busy_o)
  );

  typedef struct {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [ZW-1:0] z;
    logic [CW-1:0] col;
    bit            pass;
  } vec_t;

  typedef struct {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [ZW-1:0] z;
  } iss_t;

  typedef struct {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [CW-1:0] col;
  } out_t;

  vec_t tbl [16];
  iss_t iss_q [$];
  out_t out_q [$];

  int n_checks = 0;
  int n_fail = 0;
  int exp_pass_cnt = 0;
  int exp_fail_cnt = 0;
  int n_starts = 0;
  int n_flush = 0;
  int n_out = 0;
  int zb_lat = 3;

  bit            zb_busy = 1'b0;
  bit            zb_is_flush = 1'b0;
  bit            zb_result = 1'b0;
  int            zb_cnt = 0;
  logic [XW-1:0] zb_cx;
  logic [YW-1:0] zb_cy;
  logic [ZW-1:0] zb_cz;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (timeout or unexpected event)", name);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  // z_buffer model: samples start at the ISSUE/CLEAR cycle, answers zb_lat cycles later.
  initial begin
    zb_done_i = 1'b0;
    zb_depth_pass_i = 1'b0;
    forever begin
      @(posedge clk_i);
      #1;
      zb_done_i = 1'b0;
      zb_depth_pass_i = 1'b0;
      if (rst_i) begin
        zb_busy = 1'b0;
        continue;
      end
      if (zb_busy) begin
        chk("zb_start_single", {31'd0, zb_start_o}, 0);
        chk("zb_flush_single", {31'd0, zb_flush_o}, 0);
        if (!zb_is_flush)
          chk("zb_pixel_stable", {zb_pixel_x_o, zb_pixel_y_o, zb_pixel_z_o}, {zb_cx, zb_cy, zb_cz});
        zb_cnt--;
        if (zb_cnt == 0) begin
          zb_done_i = 1'b1;
          zb_depth_pass_i = zb_result;
          zb_busy = 1'b0;
        end
      end else if (zb_start_o) begin
        zb_busy = 1'b1;
        zb_cnt = zb_lat;
        zb_is_flush = zb_flush_o;
        zb_cx = zb_pixel_x_o;
        zb_cy = zb_pixel_y_o;
        zb_cz = zb_pixel_z_o;
        if (zb_flush_o) begin
          n_flush++;
          chk("flush_after_drain", iss_q.size(), 0);
          chk("flush_pixels_zero", {zb_pixel_x_o, zb_pixel_y_o, zb_pixel_z_o}, 0);
        end else begin
          n_starts++;
          zb_result = (zb_pixel_z_o < 8'd128);
          if (iss_q.size() == 0) fail_now("issue_unexpected");
          else begin
            iss_t e;
            e = iss_q.pop_front();
            chk("issue_xyz", {zb_pixel_x_o, zb_pixel_y_o, zb_pixel_z_o}, {e.x, e.y, e.z});
          end
        end
      end
    end
  end

  // Output scoreboard: every handshake must match the oldest expected pass.
  initial begin
    forever begin
      @(negedge clk_i);
      if (!rst_i && out_valid_o && out_ready_i) begin
        n_out++;
        if (out_q.size() == 0) fail_now("out_unexpected");
        else begin
          out_t e;
          e = out_q.pop_front();
          chk("out_xy_colour", {out_x_o, out_y_o, out_colour_o}, {e.x, e.y, e.col});
        end
      end
    end
  end

  task automatic push_frag(input vec_t v);
    int t;
    t = 0;
    frag_valid_i = 1'b1;
    frag_x_i = v.x;
    frag_y_i = v.y;
    frag_z_i = v.z;
    frag_colour_i = v.col;
    @(negedge clk_i);
    while (!frag_ready_o && t < 300) begin
      @(negedge clk_i);
      t++;
    end
    if (!frag_ready_o) fail_now("push_timeout");
    else begin
      iss_q.push_back('{v.x, v.y, v.z});
      if (v.pass) begin
        out_q.push_back('{v.x, v.y, v.col});
        if (exp_pass_cnt < SAT) exp_pass_cnt++;
      end else if (exp_fail_cnt < SAT) exp_fail_cnt++;
    end
    @(posedge clk_i);
    #1;
    frag_valid_i = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    @(negedge clk_i);
    while ((busy_o || out_q.size() != 0) && t < 1000) begin
      @(negedge clk_i);
      t++;
    end
    if (busy_o || out_q.size() != 0) fail_now(name);
    step(1);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    #2 rst_i = 1'b1;
    iss_q.delete();
    out_q.delete();
    exp_pass_cnt = 0;
    exp_fail_cnt = 0;
    @(negedge clk_i);
    #2 rst_i = 1'b0;
    step(2);
  endtask

  initial begin
    int s0, o0, t, n;
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, o0, f0, t, n;
    rst_i = 1'b1;
    frag_valid_i = 1'b0;
    frag_x_i = '0;
    frag_y_i = '0;
    frag_z_i = '0;
    frag_colour_i = '0;
    clear_req_i = 1'b0;
    out_ready_i = 1'b1;

    tbl[0]  = '{2'd1, 2'd2, 8'd5,   16'hA1B2, 1'b1};
    tbl[1]  = '{2'd3, 2'd0, 8'd200, 16'hBEEF, 1'b0};
    tbl[2]  = '{2'd0, 2'd0, 8'd10,  16'h1111, 1'b1};
    tbl[3]  = '{2'd1, 2'd1, 8'd20,  16'h2222, 1'b1};
    tbl[4]  = '{2'd2, 2'd2, 8'd30,  16'h3333, 1'b1};
    tbl[5]  = '{2'd3, 2'd3, 8'd40,  16'h4444, 1'b1};
    tbl[6]  = '{2'd0, 2'd3, 8'd50,  16'h5555, 1'b1};
    tbl[7]  = '{2'd3, 2'd0, 8'd60,  16'h6666, 1'b1};
    tbl[8]  = '{2'd1, 2'd3, 8'd127, 16'h7777, 1'b1};
    tbl[9]  = '{2'd2, 2'd0, 8'd128, 16'h8888, 1'b0};
    tbl[10] = '{2'd0, 2'd1, 8'd0,   16'h9999, 1'b1};
    tbl[11] = '{2'd3, 2'd2, 8'd255, 16'hAAAA, 1'b0};
    tbl[12] = '{2'd1, 2'd0, 8'd70,  16'hBBBB, 1'b1};
    tbl[13] = '{2'd2, 2'd1, 8'd80,  16'hCCCC, 1'b1};
    tbl[14] = '{2'd2, 2'd3, 8'd9,   16'hDDDD, 1'b1};
    tbl[15] = '{2'd3, 2'd1, 8'd15,  16'hEEEE, 1'b1};

    repeat (2) @(negedge clk_i);
    chk("rst_frag_ready", {31'd0, frag_ready_o}, 0);
    chk("rst_zb", {zb_start_o, zb_flush_o, zb_pixel_x_o, zb_pixel_y_o, zb_pixel_z_o}, 0);
    chk("rst_out", {out_valid_o, out_x_o, out_y_o, out_colour_o}, 0);
    chk("rst_misc", {pass_count_o, fail_count_o, busy_o, clear_ack_o}, 0);
    #2 rst_i = 1'b0;
    step(2);
    chk("ready_after_rst", {31'd0, frag_ready_o}, 1);

    // single passing fragment
    s0 = n_starts; o0 = n_out;
    push_frag(tbl[0]);
    wait_idle("t1_idle");
    chk("t1_starts", n_starts - s0, 1);
    chk("t1_outs", n_out - o0, 1);
    chk("t1_pass_count", pass_count_o, 1);
    chk("t1_fail_count", fail_count_o, 0);

    // single failing fragment; busy must fall within 2 cycles of done
    o0 = n_out;
    push_frag(tbl[1]);
    t = 0;
    @(negedge clk_i);
    while (!zb_done_i && t < 50) begin @(negedge clk_i); t++; end
    if (!zb_done_i) fail_now("t2_done_timeout");
    n = 0;
    do begin @(negedge clk_i); n++; end while (busy_o && n < 10);
    n_checks++;
    if (n > 2) begin
      n_fail++;
      $display("FAIL t2_busy_drop actual=%0d cycles required<=2", n);
    end
    step(1);
    chk("t2_outs", n_out - o0, 0);
    chk("t2_fail_count", fail_count_o, 1);
    chk("t2_pass_count", pass_count_o, 1);

    // six back-to-back under 20 cycles of backpressure
    o0 = n_out;
    out_ready_i = 1'b0;
    fork
      begin
        for (int i = 2; i < 8; i++) push_frag(tbl[i]);
      end
      begin
        step(15);
        chk("t3_ready_when_full", {31'd0, frag_ready_o}, 0);
        chk("t3_out_valid_stalled", {31'd0, out_valid_o}, 1);
        step(5);
        out_ready_i = 1'b1;
      end
    join
    wait_idle("t3_idle");
    chk("t3_outs", n_out - o0, 6);
    chk("t3_pass_count", pass_count_o, exp_pass_cnt);

    // mixed pass/fail including the z=127/128 boundary
    for (int i = 8; i < 12; i++) push_frag(tbl[i]);
    wait_idle("mix_idle");
    chk("mix_pass_count", pass_count_o, exp_pass_cnt);
    chk("mix_fail_count", fail_count_o, exp_fail_cnt);

    // clear with two fragments in flight; re-request while pending is a no-op
    f0 = n_flush;
    push_frag(tbl[12]);
    push_frag(tbl[13]);
    clear_req_i = 1'b1;
    step(2);
    chk("t4_ready_blocked", {31'd0, frag_ready_o}, 0);
    clear_req_i = 1'b0;
    step(1);
    clear_req_i = 1'b1;
    t = 0;
    @(negedge clk_i);
    while (!(zb_done_i && zb_is_flush) && t < 200) begin @(negedge clk_i); t++; end
    if (!(zb_done_i && zb_is_flush)) fail_now("t4_flush_done_timeout");
    chk("t4_ack_before", {31'd0, clear_ack_o}, 0);
    chk("t4_ready_during_clear", {31'd0, frag_ready_o}, 0);
    @(negedge clk_i);
    chk("t4_ack_pulse", {31'd0, clear_ack_o}, 1);
    chk("t4_ready_after_ack", {31'd0, frag_ready_o}, 1);
    clear_req_i = 1'b0;
    @(negedge clk_i);
    chk("t4_ack_single", {31'd0, clear_ack_o}, 0);
    step(1);
    wait_idle("t4_idle");
    step(4);
    chk("t4_flush_count", n_flush - f0, 1);
    chk("t4_pass_count", pass_count_o, exp_pass_cnt);

    // reset during WAIT
    push_frag(tbl[14]);
    t = 0;
    @(negedge clk_i);
    while (!zb_busy && t < 50) begin @(negedge clk_i); t++; end
    if (!zb_busy) fail_now("t5_issue_timeout");
    @(negedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    chk("t5_rst_zb", {zb_start_o, zb_flush_o, zb_pixel_x_o, zb_pixel_y_o, zb_pixel_z_o}, 0);
    chk("t5_rst_out", {out_valid_o, out_x_o, out_y_o, out_colour_o}, 0);
    chk("t5_rst_misc", {pass_count_o, fail_count_o, busy_o, frag_ready_o, clear_ack_o}, 0);
    iss_q.delete();
    out_q.delete();
    exp_pass_cnt = 0;
    exp_fail_cnt = 0;
    @(negedge clk_i);
    #2 rst_i = 1'b0;
    step(2);
    o0 = n_out;
    push_frag(tbl[15]);
    wait_idle("t5_idle");
    chk("t5_outs", n_out - o0, 1);
    chk("t5_pass_count", pass_count_o, 1);
    chk("t5_fail_count", fail_count_o, 0);

    // saturation of the 4-bit pass counter
    do_reset();
    o0 = n_out;
    for (int i = 0; i < 19; i++) begin
      vec_t v;
      v.x = 2'(i % 4);
      v.y = 2'((i / 4) % 4);
      v.z = 8'(i);
      v.col = 16'(16'h1000 + i);
      v.pass = 1'b1;
      push_frag(v);
    end
    wait_idle("t6_idle");
    chk("t6_outs", n_out - o0, 19);
    chk("t6_exp_model", exp_pass_cnt, 15);
    chk("t6_pass_sat", pass_count_o, exp_pass_cnt);
    chk("t6_fail_count", fail_count_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
